// File: rtl/rs_pkg.sv
// Shared types for the reservation station: physical tag, entry and exit packets.
package rs_pkg;
  localparam int RS_TAG_W     = 6;
  localparam int RS_PAYLOAD_W = 32;

  typedef logic [RS_TAG_W-1:0] PHYS_REG_IDX;

  localparam PHYS_REG_IDX ZERO_REG = '0;

  typedef struct packed {
    logic                    valid;
    PHYS_REG_IDX             src1_tag;
    logic                    src1_rdy;
    PHYS_REG_IDX             src2_tag;
    logic                    src2_rdy;
    logic [RS_PAYLOAD_W-1:0] payload;
  } RS_ENTRY_PACKET;

  typedef struct packed {
    PHYS_REG_IDX             src1_tag;
    PHYS_REG_IDX             src2_tag;
    logic [RS_PAYLOAD_W-1:0] payload;
  } RS_EXIT_PACKET;
endpackage

// File: rtl/multi_prio_sel.sv
// Picks the first GRANTS set bits of req (lowest index first), one one-hot vector per grant.
// Purely combinational; grants beyond the number of set bits are all-zero.
module multi_prio_sel #(
  parameter int WIDTH  = 16,
  parameter int GRANTS = 3
) (
  input  logic [WIDTH-1:0]             req,
  output logic [GRANTS-1:0][WIDTH-1:0] grant
);
  logic [WIDTH-1:0] rem;

  always_comb begin
    rem   = req;
    grant = '0;
    for (int g = 0; g < GRANTS; g++) begin
      // Isolate the lowest set bit, then retire it for the next grant.
      grant[g] = rem & (~rem + WIDTH'(1));
      rem      = rem & ~grant[g];
    end
  end
endmodule

// File: rtl/rs_wakeup_select.sv
// Reservation station: multi-lane dispatch into free slots, CDB wakeup with same-cycle bypass,
// in-order-by-index select onto ready FU ports (combinational), whole-station flush.
module rs_wakeup_select
  import rs_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 3,
  parameter int ISSUE_W   = 3,
  parameter int CDB_W     = 3,
  parameter int TAG_W     = RS_TAG_W,
  parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [DISP_W-1:0]              disp_valid,
  input  logic [DISP_W*TAG_W-1:0]        disp_src1_tag,
  input  logic [DISP_W-1:0]              disp_src1_rdy,
  input  logic [DISP_W*TAG_W-1:0]        disp_src2_tag,
  input  logic [DISP_W-1:0]              disp_src2_rdy,
  input  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload,
  input  logic [CDB_W-1:0]               cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]         cdb_tag,
  input  logic [ISSUE_W-1:0]             fu_ready,
  output logic [$clog2(DEPTH+1)-1:0]     free_count,
  output logic [ISSUE_W-1:0]             issue_valid,
  output logic [ISSUE_W*TAG_W-1:0]       issue_src1_tag,
  output logic [ISSUE_W*TAG_W-1:0]       issue_src2_tag,
  output logic [ISSUE_W*PAYLOAD_W-1:0]   issue_payload
);
  localparam int CNT_W = $clog2(DEPTH+1);

  RS_ENTRY_PACKET                entry [DEPTH];
  logic [DEPTH-1:0]              free_vec, ready_vec, issued_vec;
  logic [DISP_W-1:0][DEPTH-1:0]  alloc_oh, disp_oh;
  logic [ISSUE_W-1:0][DEPTH-1:0] sel_oh, lane_oh;

  function automatic logic cdb_hit(input PHYS_REG_IDX tag);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (cdb_valid[c] && tag != ZERO_REG && PHYS_REG_IDX'(cdb_tag[c*TAG_W +: TAG_W]) == tag)
        hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    free_count = '0;
    for (int e = 0; e < DEPTH; e++) begin
      free_vec[e]  = ~entry[e].valid;
      ready_vec[e] = entry[e].valid & entry[e].src1_rdy & entry[e].src2_rdy;
      if (!entry[e].valid) free_count = free_count + CNT_W'(1);
    end
  end

  multi_prio_sel #(.WIDTH(DEPTH), .GRANTS(DISP_W))  u_alloc (.req(free_vec),  .grant(alloc_oh));
  multi_prio_sel #(.WIDTH(DEPTH), .GRANTS(ISSUE_W)) u_select (.req(ready_vec), .grant(sel_oh));

  // k-th active dispatch lane takes the k-th free slot; a zero grant means the lane is dropped.
  always_comb begin : p_disp_map
    int rank;
    rank    = 0;
    disp_oh = '0;
    for (int l = 0; l < DISP_W; l++)
      if (disp_valid[l]) begin
        disp_oh[l] = alloc_oh[rank];
        rank++;
      end
  end

  always_comb begin : p_issue_map
    int rank;
    rank       = 0;
    lane_oh    = '0;
    issued_vec = '0;
    if (!flush)
      for (int j = 0; j < ISSUE_W; j++)
        if (fu_ready[j]) begin
          lane_oh[j] = sel_oh[rank];
          rank++;
        end
    for (int j = 0; j < ISSUE_W; j++) issued_vec = issued_vec | lane_oh[j];
  end

  always_comb begin : p_issue_out
    RS_EXIT_PACKET pkt;
    issue_valid    = '0;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    issue_payload  = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      pkt = '0;
      for (int e = 0; e < DEPTH; e++)
        if (lane_oh[j][e]) begin
          pkt.src1_tag = entry[e].src1_tag;
          pkt.src2_tag = entry[e].src2_tag;
          pkt.payload  = entry[e].payload;
        end
      issue_valid[j]                         = |lane_oh[j];
      issue_src1_tag[j*TAG_W +: TAG_W]       = TAG_W'(pkt.src1_tag);
      issue_src2_tag[j*TAG_W +: TAG_W]       = TAG_W'(pkt.src2_tag);
      issue_payload[j*PAYLOAD_W +: PAYLOAD_W] = PAYLOAD_W'(pkt.payload);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int e = 0; e < DEPTH; e++) entry[e].valid <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (issued_vec[e]) begin
          entry[e].valid <= 1'b0;
        end else if (entry[e].valid) begin
          if (cdb_hit(entry[e].src1_tag)) entry[e].src1_rdy <= 1'b1;
          if (cdb_hit(entry[e].src2_tag)) entry[e].src2_rdy <= 1'b1;
        end else begin
          for (int l = 0; l < DISP_W; l++)
            if (disp_oh[l][e]) begin
              entry[e].valid    <= 1'b1;
              entry[e].src1_tag <= PHYS_REG_IDX'(disp_src1_tag[l*TAG_W +: TAG_W]);
              entry[e].src2_tag <= PHYS_REG_IDX'(disp_src2_tag[l*TAG_W +: TAG_W]);
              entry[e].src1_rdy <= disp_src1_rdy[l] || cdb_hit(PHYS_REG_IDX'(disp_src1_tag[l*TAG_W +: TAG_W]))
                                   || PHYS_REG_IDX'(disp_src1_tag[l*TAG_W +: TAG_W]) == ZERO_REG;
              entry[e].src2_rdy <= disp_src2_rdy[l] || cdb_hit(PHYS_REG_IDX'(disp_src2_tag[l*TAG_W +: TAG_W]))
                                   || PHYS_REG_IDX'(disp_src2_tag[l*TAG_W +: TAG_W]) == ZERO_REG;
              entry[e].payload  <= RS_PAYLOAD_W'(disp_payload[l*PAYLOAD_W +: PAYLOAD_W]);
            end
        end
      end
    end
  end

  // Upstream must never dispatch more than the free slots it was shown.
  always_ff @(posedge clock)
    if (!reset && !flush) assert ($countones(disp_valid) <= int'(free_count));
endmodule

// File: tb/tb_rs_wakeup_select.sv
// Randomized + directed bench for rs_wakeup_select against a list-based reference model.
module tb_rs_wakeup_select;
  localparam int DEPTH = 16, DW = 3, IW = 3, CW = 3, TW = 6, PW = 32;

  logic clock = 1'b0, reset, flush;
  logic [DW-1:0] disp_valid, disp_src1_rdy, disp_src2_rdy;
  logic [DW*TW-1:0] disp_src1_tag, disp_src2_tag;
  logic [DW*PW-1:0] disp_payload;
  logic [CW-1:0] cdb_valid;
  logic [CW*TW-1:0] cdb_tag;
  logic [IW-1:0] fu_ready, issue_valid;
  logic [4:0] free_count;
  logic [IW*TW-1:0] issue_src1_tag, issue_src2_tag;
  logic [IW*PW-1:0] issue_payload;

  rs_wakeup_select dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy), .disp_payload(disp_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_ready(fu_ready),
    .free_count(free_count), .issue_valid(issue_valid), .issue_src1_tag(issue_src1_tag),
    .issue_src2_tag(issue_src2_tag), .issue_payload(issue_payload)
  );

  always #10 clock = ~clock;

  // Reference model: one record per slot.
  bit        m_v [DEPTH];
  bit [5:0]  m_t1 [DEPTH], m_t2 [DEPTH];
  bit        m_r1 [DEPTH], m_r2 [DEPTH];
  bit [31:0] m_p [DEPTH];
  bit        model_ok = 0;
  int vectors = 0, miscompares = 0;

  function automatic bit on_cdb(bit [5:0] t);
    for (int c = 0; c < CW; c++)
      if (cdb_valid[c] && t != 0 && cdb_tag[c*TW +: TW] == t) return 1;
    return 0;
  endfunction

  function automatic int model_free();
    int n = 0;
    for (int e = 0; e < DEPTH; e++) if (!m_v[e]) n++;
    return n;
  endfunction

  // Which slot each issue lane should carry (-1 = none).
  function automatic void model_issue(output int pick [IW]);
    int rdy [$];
    int k = 0;
    for (int e = 0; e < DEPTH; e++) if (m_v[e] && m_r1[e] && m_r2[e]) rdy.push_back(e);
    for (int j = 0; j < IW; j++) begin
      pick[j] = -1;
      if (!flush && fu_ready[j] && k < rdy.size()) begin pick[j] = rdy[k]; k++; end
    end
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int pick [IW];
    logic [IW-1:0] ev;
    logic [IW*TW-1:0] e1, e2;
    logic [IW*PW-1:0] ep;
    model_issue(pick);
    ev = '0; e1 = '0; e2 = '0; ep = '0;
    for (int j = 0; j < IW; j++)
      if (pick[j] >= 0) begin
        ev[j] = 1'b1;
        e1[j*TW +: TW] = m_t1[pick[j]];
        e2[j*TW +: TW] = m_t2[pick[j]];
        ep[j*PW +: PW] = m_p[pick[j]];
      end
    vectors++;
    chk("free_count", 64'(free_count), 64'(model_free()));
    chk("issue_valid", 64'(issue_valid), 64'(ev));
    chk("issue_src1_tag", 64'(issue_src1_tag), 64'(e1));
    chk("issue_src2_tag", 64'(issue_src2_tag), 64'(e2));
    for (int j = 0; j < IW; j++) chk("issue_payload", 64'(issue_payload[j*PW +: PW]), 64'(ep[j*PW +: PW]));
  endtask

  task automatic model_update();
    int pick [IW];
    int fl [$];
    int k = 0;
    bit [5:0] t;
    if (reset || flush) begin
      model_ok = 1;
      for (int e = 0; e < DEPTH; e++) m_v[e] = 0;
      return;
    end
    model_issue(pick);
    for (int e = 0; e < DEPTH; e++) if (!m_v[e]) fl.push_back(e);
    for (int e = 0; e < DEPTH; e++)
      if (m_v[e]) begin
        if (on_cdb(m_t1[e])) m_r1[e] = 1;
        if (on_cdb(m_t2[e])) m_r2[e] = 1;
      end
    for (int j = 0; j < IW; j++) if (pick[j] >= 0) m_v[pick[j]] = 0;
    for (int l = 0; l < DW; l++)
      if (disp_valid[l]) begin
        if (k < fl.size()) begin
          m_v[fl[k]] = 1;
          t = disp_src1_tag[l*TW +: TW];
          m_t1[fl[k]] = t; m_r1[fl[k]] = disp_src1_rdy[l] || t == 0 || on_cdb(t);
          t = disp_src2_tag[l*TW +: TW];
          m_t2[fl[k]] = t; m_r2[fl[k]] = disp_src2_rdy[l] || t == 0 || on_cdb(t);
          m_p[fl[k]] = disp_payload[l*PW +: PW];
        end
        k++;
      end
  endtask

  task automatic cyc();
    @(negedge clock);
    if (model_ok) compare_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic clear_in();
    flush = 0; disp_valid = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_payload = '0;
    cdb_valid = '0; cdb_tag = '0;
  endtask

  task automatic lane(int l, bit [5:0] t1, bit r1, bit [5:0] t2, bit r2, bit [31:0] p);
    disp_valid[l] = 1'b1;
    disp_src1_tag[l*TW +: TW] = t1; disp_src1_rdy[l] = r1;
    disp_src2_tag[l*TW +: TW] = t2; disp_src2_rdy[l] = r2;
    disp_payload[l*PW +: PW] = p;
  endtask

  task automatic cdb(int c, bit [5:0] t);
    cdb_valid[c] = 1'b1; cdb_tag[c*TW +: TW] = t;
  endtask

  initial begin
    reset = 1; fu_ready = '0; clear_in();
    cyc(); cyc();
    reset = 0;
    #1 chk("reset free", 64'(free_count), 16);
    chk("reset issue_valid", 64'(issue_valid), 0);
    chk("reset payload", 64'(issue_payload), 0);

    // Three all-ready dispatches, then issue together.
    fu_ready = 3'b111;
    lane(0, 0, 0, 0, 0, 32'h100); lane(1, 0, 0, 0, 0, 32'h101); lane(2, 0, 0, 0, 0, 32'h102);
    cyc(); clear_in();
    #1 chk("t1 free", 64'(free_count), 13);
    chk("t1 issue_valid", 64'(issue_valid), 3'b111);
    chk("t1 lane0 payload", 64'(issue_payload[31:0]), 32'h100);
    chk("t1 lane2 payload", 64'(issue_payload[95:64]), 32'h102);
    cyc();
    #1 chk("t1 free after", 64'(free_count), 16);

    // Wakeup from CDB two cycles after dispatch.
    lane(0, 5, 0, 0, 0, 32'h200);
    cyc(); clear_in();
    #1 chk("t2 wait0", 64'(issue_valid), 0);
    cyc();
    cdb(0, 5);
    #1 chk("t2 wait1", 64'(issue_valid), 0);
    cyc(); clear_in();
    #1 chk("t2 issue", 64'(issue_valid), 3'b001);
    chk("t2 payload", 64'(issue_payload[31:0]), 32'h200);
    chk("t2 src1", 64'(issue_src1_tag[5:0]), 5);
    cyc();
    #1 chk("t2 free", 64'(free_count), 16);

    // Same-cycle CDB bypass into dispatch.
    lane(0, 7, 0, 0, 0, 32'h333); cdb(1, 7);
    cyc(); clear_in();
    #1 chk("t3 bypass issue", 64'(issue_valid), 3'b001);
    chk("t3 payload", 64'(issue_payload[31:0]), 32'h333);
    cyc();

    // Fill all slots, then partial FU availability.
    fu_ready = 3'b000;
    for (int c = 0; c < 6; c++) begin
      for (int l = 0; l < DW; l++)
        if (c < 5 || l == 0) lane(l, 0, 1, 0, 1, 32'h400 + 32'(3*c + l));
      cyc(); clear_in();
    end
    #1 chk("t4 full", 64'(free_count), 0);
    fu_ready = 3'b101;
    #1 chk("t4 issue_valid", 64'(issue_valid), 3'b101);
    chk("t4 lane0", 64'(issue_payload[31:0]), 32'h400);
    chk("t4 lane1", 64'(issue_payload[63:32]), 0);
    chk("t4 lane2", 64'(issue_payload[95:64]), 32'h401);
    cyc();
    #1 chk("t4 free", 64'(free_count), 2);
    fu_ready = 3'b111;
    repeat (6) cyc();
    #1 chk("t4 drained", 64'(free_count), 16);

    // Flush with concurrent dispatch, wakeup and ready FUs.
    fu_ready = 3'b000;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < DW; l++)
        if (c < 3 || l == 0) lane(l, (l == 1) ? 6'd9 : 6'd0, 0, 0, 0, 32'h500 + 32'(3*c + l));
      cyc(); clear_in();
    end
    flush = 1; fu_ready = 3'b111;
    lane(0, 0, 0, 0, 0, 32'h5AA); lane(2, 0, 0, 0, 0, 32'h5AB); cdb(0, 9);
    #1 chk("t5 flush issue", 64'(issue_valid), 0);
    cyc(); clear_in(); cdb(0, 9);
    #1 chk("t5 free", 64'(free_count), 16);
    chk("t5 issue after", 64'(issue_valid), 0);
    repeat (3) cyc();
    chk("t5 no late issue", 64'(issue_valid), 0);
    clear_in();

    // Reset with waiting entries.
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < DW; l++) if (c < 2 || l < 2) lane(l, 11, 0, 0, 1, 32'h600 + 32'(l));
      cyc(); clear_in();
    end
    reset = 1;
    cyc();
    reset = 0;
    #1 chk("t6 free", 64'(free_count), 16);
    chk("t6 issue_valid", 64'(issue_valid), 0);
    chk("t6 payload", 64'(issue_payload), 0);
    cdb(0, 11);
    cyc(); clear_in();
    #1 chk("t6 no issue", 64'(issue_valid), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int room;
      clear_in();
      room = model_free();
      for (int l = 0; l < DW; l++)
        if ($urandom_range(0, 2) != 0 && room > 0) begin
          lane(l, 6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0), $urandom);
          room--;
        end
      for (int c = 0; c < CW; c++) if ($urandom_range(0, 1) != 0) cdb(c, 6'($urandom_range(0, 7)));
      fu_ready = 3'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 0; clear_in();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rs_wakeup_select.md
Name: rs_wakeup_select

Overview:
- Parametrised reservation station for the N-way out-of-order core; successor to the single-configuration RS.
- Accepts up to DISP_W renamed instructions per cycle into free slots.
- Wakes source operands from up to CDB_W broadcast tags per cycle, and selects up to ISSUE_W ready entries to the FUs that are free.
- Adds a whole-station flush for mispredict recovery and a free-slot count for dispatch back-pressure.

Parameters:
- DEPTH, 16, number of entries (power of two not required, ≥ 2).
- DISP_W, 3, dispatch lanes per cycle.
- ISSUE_W, 3, issue lanes, one per FU port.
- CDB_W, 3, CDB broadcast lanes.
- TAG_W, 6, physical register tag width.
- PAYLOAD_W, 32, opaque per-instruction payload (opcode, dest tag, imm, ROB idx) carried through unchanged.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- flush  in  1  squash all entries
- disp_valid  in  DISP_W  per-lane dispatch request
- disp_src1_tag  in  DISP_W*TAG_W  source 1 tags
- disp_src1_rdy  in  DISP_W  source 1 already available
- disp_src2_tag  in  DISP_W*TAG_W  source 2 tags
- disp_src2_rdy  in  DISP_W  source 2 already available
- disp_payload  in  DISP_W*PAYLOAD_W  payload
- cdb_valid  in  CDB_W  broadcast valid
- cdb_tag  in  CDB_W*TAG_W  broadcast tags
- fu_ready  in  ISSUE_W  FU port j can accept this cycle
- free_count  out  $clog2(DEPTH+1)  empty entries
- issue_valid  out  ISSUE_W  issue lane j carries an instruction
- issue_src1_tag  out  ISSUE_W*TAG_W  issued source 1 tags
- issue_src2_tag  out  ISSUE_W*TAG_W  issued source 2 tags
- issue_payload  out  ISSUE_W*PAYLOAD_W  issued payload

Behaviour:
- Clock is `clock`. Reset is `reset`: synchronous, active-high.
- Reset: all entry valid bits cleared. free_count = DEPTH; issue_valid = 0; issue tag/payload outputs = 0.
- Entry state (registered): valid, src1_tag, src1_rdy, src2_tag, src2_rdy, payload.

Dispatch:
- disp_valid may be non-contiguous.
- The k-th set lane (ascending lane index) is written into the k-th lowest-index entry empty at the start of the cycle.
- Upstream guarantees popcount(disp_valid) ≤ free_count. Violation: excess lanes are dropped and an assertion fires.
- Same-cycle bypass: if a dispatched source tag equals any valid cdb_tag this cycle, its rdy bit is stored as 1.

Wakeup:
- Every valid entry compares both source tags against all CDB lanes.
- A match sets the rdy bit at the next edge. The entry is issuable from the following cycle.
- Tag 0 is the hardwired zero register:
  - dispatched src tag 0 is stored ready;
  - cdb_tag 0 is ignored.

Select and issue (combinational from registered state; zero latency):
- An entry is ready when valid & src1_rdy & src2_rdy.
- Ready entries are granted in ascending index order to issue lanes whose fu_ready is set, in ascending lane order.
- Lanes with fu_ready=0 get issue_valid=0.
- Granted entries are cleared at the next edge. Freed slots appear in free_count in the cycle after issue.
- There is no dispatch-to-issue bypass: an entry written at edge t is issuable no earlier than the cycle after t.
- Non-issuing lanes drive zero tags and payload.

free_count:
- Popcount of empty entries in registered state.
- Does not include slots freed or filled this cycle.

Flush:
- issue_valid forced to 0 in the flush cycle.
- All valid bits cleared at the next edge.
- Flush overrides same-cycle dispatch, issue and wakeup.
- free_count = DEPTH the following cycle.

Simultaneous events:
- Issue of entry e and dispatch into a different slot in the same cycle are independent.
- A slot freed this cycle is not reused until the next cycle.
- A CDB match on an entry granted this cycle has no effect.

Decomposition:
- Shared package rs_pkg holds:
  - PHYS_REG_IDX (TAG_W-bit tag type);
  - RS_ENTRY_PACKET (valid, two tag/rdy pairs, payload);
  - RS_EXIT_PACKET (two tags, payload);
  - ZERO_REG = 0.
- Sub-module multi_prio_sel #(WIDTH, GRANTS):
  - returns the first GRANTS set bits of a request vector as one-hot per grant;
  - instanced once for allocation (request = ~valid) and once for select (request = ready).

Test Plan:
- Reset, then 3 lanes dispatch all-ready (tags 0) → free_count 16→13 next cycle; with fu_ready=3'b111, all three issue from entries 0,1,2 one cycle later; free_count 16 the cycle after.
- Dispatch entry with src1=5 not ready, src2=0; CDB tag 5 two cycles later → issue_valid asserted exactly the cycle after the CDB broadcast, never before.
- Dispatch src1=7 not ready while cdb_tag lane 1 = 7 in the same cycle → entry issues the next cycle (bypass).
- Fill 16 entries all ready, fu_ready=3'b101 → lanes 0 and 2 issue entries 0,1; lane 1 issue_valid=0; free_count goes 0→2.
- With 10 entries valid, assert flush together with 2-lane dispatch and CDB traffic → issue_valid=0 that cycle; free_count=16 next cycle; no later issue of squashed payloads.
- Assert reset mid-stream with 8 waiting entries → all outputs at reset values next cycle; subsequent CDB tags cause no issue.
